// File: rtl/demux4way32bit_buf.sv
// ============================================================================
// Module   : demux4way32bit_buf
// Purpose  : Registered 1-to-4 demux for 32-bit words. Each output has a
//            one-entry valid/ready holding register and a delivery counter.
//            Optional broadcast is built only when DEMUX4_BCAST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux4way32bit_buf #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [31:0]      out_data0,
  output logic [31:0]      out_data1,
  output logic [31:0]      out_data2,
  output logic [31:0]      out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0]       w_can_accept;
  logic [3:0]       w_drain;
  logic [3:0]       w_load;
  logic             w_accept;
  logic [31:0]      w_data [4];
  logic [CNT_W-1:0] w_cnt  [4];

  assign w_can_accept = ~out_valid | out_ready;
  assign w_drain      = out_valid & out_ready;
  assign w_accept     = in_valid & in_ready;

`ifdef DEMUX4_BCAST_EN
  always_comb begin
    if (in_bcast) in_ready = &w_can_accept;
    else          in_ready = w_can_accept[in_sel];
  end

  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      if (in_bcast) w_load = 4'b1111;
      else          w_load[in_sel] = 1'b1;
    end
  end
`else
  logic w_unused_bcast;
  assign w_unused_bcast = in_bcast;

  assign in_ready = w_can_accept[in_sel];

  always_comb begin
    w_load = 4'b0000;
    if (w_accept) w_load[in_sel] = 1'b1;
  end
`endif

  // A same-cycle load wins over drain, so a port streams one word per cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      logic             r_valid;
      logic [31:0]      r_data;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_cnt   <= '0;
        end else begin
          if (w_load[gi]) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
          end else if (w_drain[gi]) begin
            r_valid <= 1'b0;
          end
          if (w_drain[gi]) r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign out_valid[gi] = r_valid;
      assign w_data[gi]    = r_data;
      assign w_cnt[gi]     = r_cnt;
    end
  endgenerate

  assign out_data0 = w_data[0];
  assign out_data1 = w_data[1];
  assign out_data2 = w_data[2];
  assign out_data3 = w_data[3];
  assign cnt0      = w_cnt[0];
  assign cnt1      = w_cnt[1];
  assign cnt2      = w_cnt[2];
  assign cnt3      = w_cnt[3];

endmodule

`default_nettype wire

// File: tb/tb_demux4way32bit_buf.sv
// ============================================================================
// Module   : tb_demux4way32bit_buf
// Purpose  : Directed plus random bench for demux4way32bit_buf with a
//            queue-based scoreboard (honours DEMUX4_BCAST_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux4way32bit_buf;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic [1:0]       in_sel = '0;
  logic             in_bcast = 1'b0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [31:0]      out_data0, out_data1, out_data2, out_data3;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  int errors = 0;
  int checks = 0;

  demux4way32bit_buf #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  logic [31:0]      dut_data [4];
  logic [CNT_W-1:0] dut_cnt  [4];
  assign dut_data[0] = out_data0;
  assign dut_data[1] = out_data1;
  assign dut_data[2] = out_data2;
  assign dut_data[3] = out_data3;
  assign dut_cnt[0]  = cnt0;
  assign dut_cnt[1]  = cnt1;
  assign dut_cnt[2]  = cnt2;
  assign dut_cnt[3]  = cnt3;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: each port is a queue of at most one pending word.
  logic [31:0] exp_q [4][$];
  logic [31:0] last_out [4];
  int          cnt_m [4];
  bit          armed = 0;

  always @(negedge clk) begin
    logic [3:0] ca;
    logic       bc;
    logic       rdy;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        last_out[i] = '0;
        cnt_m[i] = 0;
      end
      armed = 1;
    end else if (armed) begin
      for (int i = 0; i < 4; i++) ca[i] = (exp_q[i].size() == 0) || out_ready[i];
      bc = 1'b0;
`ifdef DEMUX4_BCAST_EN
      bc = in_bcast;
`endif
      rdy = bc ? (ca == 4'hF) : ca[in_sel];
      chk("in_ready", 64'(in_ready), 64'(rdy));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
        chk($sformatf("out_data%0d", i), 64'(dut_data[i]),
            64'((exp_q[i].size() != 0) ? exp_q[i][0] : last_out[i]));
        chk($sformatf("cnt%0d", i), 64'(dut_cnt[i]), 64'(cnt_m[i] % (1 << CNT_W)));
      end
      for (int i = 0; i < 4; i++)
        if (exp_q[i].size() != 0 && out_ready[i]) begin
          last_out[i] = exp_q[i].pop_front();
          cnt_m[i]++;
        end
      if (in_valid && rdy)
        for (int i = 0; i < 4; i++)
          if (bc || in_sel == 2'(i)) exp_q[i].push_back(in_data);
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] s, input logic b);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sel = s; in_bcast = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_bcast = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_cnt0", 64'(cnt0), 64'h0);
    @(posedge clk); #1;

    // Single load into port 2.
    out_ready = 4'b0000;
    send(32'hDEADBEEF, 2'd2, 1'b0);
    @(negedge clk);
    chk("load_out_valid", 64'(out_valid), 64'h4);
    chk("load_out_data2", 64'(out_data2), 64'hDEADBEEF);
    @(posedge clk); #1;

    // Backpressure on port 1, then reroute to port 3.
    send(32'h11111111, 2'd1, 1'b0);
    in_valid = 1'b1; in_data = 32'h22222222; in_sel = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_out_data1", 64'(out_data1), 64'h11111111);
    end
    @(posedge clk); #1;
    send(32'h22222222, 2'd3, 1'b0);
    @(negedge clk);
    chk("bp_out_data3", 64'(out_data3), 64'h22222222);
    chk("bp_out_valid", 64'(out_valid), 64'hE);
    @(posedge clk); #1;

    // Streaming 1..10 into port 0.
    do_reset();
    out_ready = 4'b0001;
    for (int k = 1; k <= 10; k++) send(32'(k), 2'd0, 1'b0);
    idle(2);
    @(negedge clk);
    chk("stream_cnt0", 64'(cnt0), 64'd10);
    @(posedge clk); #1;

    // Counter wrap on port 3 (CNT_W=4, 17 handshakes).
    do_reset();
    out_ready = 4'b1000;
    for (int k = 0; k < 17; k++) send(32'h300 + 32'(k), 2'd3, 1'b0);
    idle(2);
    @(negedge clk);
    chk("wrap_cnt3", 64'(cnt3), 64'd1);
    chk("wrap_cnt012", 64'({cnt0, cnt1, cnt2}), 64'h0);
    @(posedge clk); #1;

    // Reset in the middle of traffic.
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) send(32'hA0 + 32'(k), 2'(k), 1'b0);
    in_valid = 1'b1; in_data = 32'hBADBAD00; in_sel = 2'd0;
    do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_data", 64'(out_data0 | out_data1 | out_data2 | out_data3), 64'h0);
    chk("midrst_cnt3", 64'(cnt3), 64'h0);
    @(posedge clk); #1;

    // Broadcast with port 2 stalled.
    send(32'h55555555, 2'd2, 1'b0);
    in_valid = 1'b1; in_data = 32'h12345678; in_sel = 2'd0; in_bcast = 1'b1;
`ifdef DEMUX4_BCAST_EN
    repeat (2) begin
      @(negedge clk);
      chk("bcast_stall_in_ready", 64'(in_ready), 64'h0);
    end
    @(posedge clk); #1;
    out_ready = 4'b0100;
    send(32'h12345678, 2'd0, 1'b1);
    @(negedge clk);
    chk("bcast_out_valid", 64'(out_valid), 64'hF);
    chk("bcast_data", 64'(out_data0 & out_data1 & out_data2 & out_data3), 64'h12345678);
`else
    send(32'h12345678, 2'd0, 1'b1);
    @(negedge clk);
    chk("nobcast_out_valid", 64'(out_valid), 64'h5);
    chk("nobcast_data0", 64'(out_data0), 64'h12345678);
`endif
    @(posedge clk); #1;

    // Random traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = $urandom;
      in_sel    = 2'($urandom_range(0, 3));
      in_bcast  = ($urandom_range(0, 99) < 15);
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(0, 99) < 65);
      rst_n     = ($urandom_range(0, 299) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'hF;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
